// File: rtl/tdm_demux_rx.sv
// Time-division demultiplexer: gathers CHANNELS consecutive words that follow a
// start-of-frame marker and publishes them together as one frame.
module tdm_demux_rx #(
    parameter int WIDTH = 8,
    parameter int SELW  = 2
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic [WIDTH-1:0]              d,
    input  logic                          d_valid,
    input  logic                          d_sof,
    output logic [(2**SELW)*WIDTH-1:0]    y,
    output logic                          y_valid,
    output logic [SELW-1:0]               ch,
    output logic                          busy,
    output logic                          frame_err
);

    localparam int CHANNELS = 2**SELW;
    localparam logic [SELW-1:0] LAST_CH = SELW'(CHANNELS - 1);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t                       state_q, state_d;
    logic [SELW-1:0]              ch_q, ch_d;
    logic [CHANNELS*WIDTH-1:0]    y_q, y_d;
    logic                         y_valid_q, y_valid_d;
    logic                         frame_err_q, frame_err_d;

    // The final slot is never buffered: it comes straight from d on completion.
    logic [WIDTH-1:0]             shadow_q [CHANNELS-1];
    logic                         shadow_we;
    logic [SELW-1:0]              shadow_idx;
    logic [CHANNELS*WIDTH-1:0]    frame_full;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_assemble
            if (gi == CHANNELS - 1) begin : g_last
                assign frame_full[gi*WIDTH +: WIDTH] = d;
            end else begin : g_buf
                assign frame_full[gi*WIDTH +: WIDTH] = shadow_q[gi];
            end
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        y_d         = y_q;
        y_valid_d   = 1'b0;
        frame_err_d = 1'b0;
        shadow_we   = 1'b0;
        shadow_idx  = ch_q;

        if (d_valid) begin
            case (state_q)
                IDLE: begin
                    if (d_sof) begin
                        shadow_we  = 1'b1;
                        shadow_idx = '0;
                        ch_d       = SELW'(1);
                        state_d    = COLLECT;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                COLLECT: begin
                    if (d_sof) begin
                        // Short frame: drop the partial one, restart from this word.
                        frame_err_d = 1'b1;
                        shadow_we   = 1'b1;
                        shadow_idx  = '0;
                        ch_d        = SELW'(1);
                    end else if (ch_q == LAST_CH) begin
                        y_d       = frame_full;
                        y_valid_d = 1'b1;
                        ch_d      = '0;
                        state_d   = IDLE;
                    end else begin
                        shadow_we = 1'b1;
                        ch_d      = ch_q + SELW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    ch_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int k = 0; k < CHANNELS - 1; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CHANNELS - 1; k++) begin
                if (shadow_we && shadow_idx == SELW'(k)) begin
                    shadow_q[k] <= d;
                end
            end
        end
    end

    assign y         = y_q;
    assign y_valid   = y_valid_q;
    assign ch        = ch_q;
    assign busy      = (state_q == COLLECT);
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Bench for tdm_demux_rx: directed scenarios plus a randomized stream checked
// against a queue-based frame model.
module tb_tdm_demux_rx;

    localparam int W    = 8;
    localparam int SELW = 2;
    localparam int CH   = 2**SELW;

    logic              clk = 1'b0;
    logic              clrn;
    logic [W-1:0]      d;
    logic              d_valid;
    logic              d_sof;
    logic [CH*W-1:0]   y;
    logic              y_valid;
    logic [SELW-1:0]   ch;
    logic              busy;
    logic              frame_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: words of the frame in progress, plus last published frame.
    logic [W-1:0]      m_buf[$];
    bit                m_coll;
    logic [CH*W-1:0]   m_y;
    bit                m_yv;
    bit                m_err;

    tdm_demux_rx #(.WIDTH(W), .SELW(SELW)) dut (
        .clk(clk), .clrn(clrn), .d(d), .d_valid(d_valid), .d_sof(d_sof),
        .y(y), .y_valid(y_valid), .ch(ch), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [SELW-1:0] m_ch();
        return m_coll ? SELW'(m_buf.size()) : '0;
    endfunction

    task automatic model_reset();
        m_buf.delete();
        m_coll = 0;
        m_y    = '0;
        m_yv   = 0;
        m_err  = 0;
    endtask

    task automatic model_edge(input logic v, input logic s, input logic [W-1:0] w);
        m_yv  = 0;
        m_err = 0;
        if (v) begin
            if (s) begin
                if (m_coll) m_err = 1;
                m_buf.delete();
                m_buf.push_back(w);
                m_coll = 1;
            end else if (!m_coll) begin
                m_err = 1;
            end else begin
                m_buf.push_back(w);
                if (m_buf.size() == CH) begin
                    for (int k = 0; k < CH; k++) m_y[k*W +: W] = m_buf[k];
                    m_yv   = 1;
                    m_coll = 0;
                    m_buf.delete();
                end
            end
        end
    endtask

    // Drive one cycle of input, advance the model at the edge, settle for sampling.
    task automatic step(input logic v, input logic s, input logic [W-1:0] w);
        d_valid = v;
        d_sof   = s;
        d       = w;
        @(posedge clk);
        model_edge(v, s, w);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        d_valid = 1'b0; d_sof = 1'b0; d = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        clrn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (y !== '0 || y_valid !== 1'b0 || frame_err !== 1'b0 || ch !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset: y=%h yv=%b err=%b ch=%0d busy=%b required all zero",
                     y, y_valid, frame_err, ch, busy);
        end
    endtask

    task automatic test_clean_frame();
        logic [W-1:0]    words [CH];
        logic [SELW-1:0] exp_ch [CH];
        words  = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_ch = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < CH; i++) begin
            step(1'b1, i == 0, words[i]);
            total++;
            if (ch !== exp_ch[i] || y_valid !== (i == CH - 1)) begin
                bad++;
                $display("FAIL clean_seq[%0d]: ch=%0d yv=%b required ch=%0d yv=%b",
                         i, ch, y_valid, exp_ch[i], i == CH - 1);
            end
        end
        total++;
        if (y !== 32'h44332211) begin
            bad++;
            $display("FAIL clean_y: y=%h required 44332211", y);
        end
        step(1'b0, 1'b0, 8'h00);
        total++;
        if (y_valid !== 1'b0 || y !== 32'h44332211) begin
            bad++;
            $display("FAIL clean_hold: yv=%b y=%h required yv=0 y=44332211", y_valid, y);
        end
        $display("clean frame: y=%h", y);
    endtask

    task automatic test_gapped_frame();
        logic [W-1:0] words [CH];
        int nvalid = 0;
        int busy_bad = 0;
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < CH; i++) begin
            step(1'b1, i == 0, words[i]);
            if (y_valid) nvalid++;
            if (i < CH - 1) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'b0, 8'hEE);
                    if (!busy) busy_bad++;
                    if (y_valid) nvalid++;
                end
            end
        end
        repeat (3) begin
            step(1'b0, 1'b0, 8'h00);
            if (y_valid) nvalid++;
        end
        total++;
        if (busy_bad != 0) begin
            bad++;
            $display("FAIL gapped_busy: busy low on %0d gap cycles required 0", busy_bad);
        end
        total++;
        if (nvalid != 1 || y !== 32'h44332211) begin
            bad++;
            $display("FAIL gapped_y: y_valid count=%0d y=%h required 1 44332211", nvalid, y);
        end
        $display("gapped frame: y=%h pulses=%0d", y, nvalid);
    endtask

    task automatic test_premature_sof();
        logic [W-1:0] words [6];
        bit           sofs  [6];
        int nvalid = 0;
        words = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        sofs  = '{1, 0, 1, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, sofs[i], words[i]);
            if (y_valid) nvalid++;
            total++;
            if (frame_err !== (i == 2)) begin
                bad++;
                $display("FAIL premature_err[%0d]: err=%b required %b", i, frame_err, i == 2);
            end
        end
        step(1'b0, 1'b0, 8'h00);
        if (y_valid) nvalid++;
        total++;
        if (y !== 32'hFFEEDDCC || nvalid != 1) begin
            bad++;
            $display("FAIL premature_y: y=%h pulses=%0d required FFEEDDCC 1", y, nvalid);
        end
        $display("premature sof: y=%h", y);
    endtask

    task automatic test_orphan();
        logic [CH*W-1:0] y_before;
        y_before = y;
        step(1'b1, 1'b0, 8'h55);
        total++;
        if (frame_err !== 1'b1 || y !== y_before || ch !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL orphan: err=%b y=%h ch=%0d busy=%b required 1 %h 0 0",
                     frame_err, y, ch, busy, y_before);
        end
        step(1'b0, 1'b0, 8'h00);
        total++;
        if (frame_err !== 1'b0) begin
            bad++;
            $display("FAIL orphan_pulse: err=%b required 0 one cycle later", frame_err);
        end
        $display("orphan word: err pulse seen, y=%h", y);
    endtask

    task automatic test_back_to_back();
        int pulse_cyc[$];
        int nerr = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < CH; i++) begin
                step(1'b1, i == 0, W'(16 * f + i + 1));
                if (y_valid) pulse_cyc.push_back(cyc);
                if (frame_err) nerr++;
            end
        end
        step(1'b0, 1'b0, 8'h00);
        if (y_valid) pulse_cyc.push_back(cyc);
        total++;
        if (pulse_cyc.size() != 2 || nerr != 0) begin
            bad++;
            $display("FAIL b2b_count: pulses=%0d errs=%0d required 2 0", pulse_cyc.size(), nerr);
        end else begin
            total++;
            if (pulse_cyc[1] - pulse_cyc[0] != CH || y !== 32'h14131211) begin
                bad++;
                $display("FAIL b2b_spacing: gap=%0d y=%h required %0d 14131211",
                         pulse_cyc[1] - pulse_cyc[0], y, CH);
            end
        end
        $display("back-to-back: pulses=%0d y=%h", pulse_cyc.size(), y);
    endtask

    task automatic test_reset_midframe();
        step(1'b1, 1'b1, 8'h77);
        step(1'b1, 1'b0, 8'h88);
        #2;
        clrn = 1'b0;
        model_reset();
        #1;
        total++;
        if (y !== '0 || y_valid !== 1'b0 || busy !== 1'b0 || ch !== '0) begin
            bad++;
            $display("FAIL midframe_reset: y=%h yv=%b busy=%b ch=%0d required zeros",
                     y, y_valid, busy, ch);
        end
        @(posedge clk);
        #1;
        clrn = 1'b1;
        for (int i = 0; i < CH; i++) step(1'b1, i == 0, W'(i + 1));
        total++;
        if (y !== 32'h04030201 || y_valid !== 1'b1) begin
            bad++;
            $display("FAIL midframe_new: y=%h yv=%b required 04030201 1", y, y_valid);
        end
        $display("reset mid-frame: new y=%h", y);
    endtask

    task automatic test_random();
        int nerr_cmp = 0;
        int npub = 0;
        for (int n = 0; n < 400; n++) begin
            logic v, s;
            v = ($urandom_range(0, 9) < 7);
            s = m_coll ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 8);
            step(v, s, W'($urandom));
            if (m_yv) npub++;
            total++;
            if (y !== m_y || y_valid !== m_yv || frame_err !== m_err ||
                ch !== m_ch() || busy !== m_coll || (y_valid && frame_err)) begin
                bad++;
                nerr_cmp++;
                if (nerr_cmp <= 5)
                    $display("FAIL random[%0d]: y=%h yv=%b err=%b ch=%0d busy=%b required %h %b %b %0d %b",
                             n, y, y_valid, frame_err, ch, busy, m_y, m_yv, m_err, m_ch(), m_coll);
            end
        end
        $display("random stream: 400 cycles, %0d frames published", npub);
    endtask

    initial begin
        clrn = 1'b0;
        d = '0; d_valid = 1'b0; d_sof = 1'b0;
        test_reset();
        test_clean_frame();
        test_gapped_frame();
        test_premature_sof();
        test_orphan();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
